// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial add/subtract datapath.
package alu_pkg;

  localparam int NIBBLE_W = 4;
  localparam int DATA_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } adder_state_t;

endpackage

// File: rtl/nibble_add4.sv
// 4-bit carry-select adder slice: the low pair ripples from cin while the
// high pair is precomputed for both carry-in values and picked by the low
// pair's carry.
module nibble_add4
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [2:0] lo;
  logic [2:0] hi_c0;
  logic [2:0] hi_c1;
  logic [2:0] hi_sel;

  // Low half ripples; high half is evaluated for both carries in parallel.
  always_comb begin
    lo     = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
    hi_c0  = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    hi_c1  = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
    hi_sel = lo[2] ? hi_c1 : hi_c0;
    sum    = {hi_sel[1:0], lo[1:0]};
    cout   = hi_sel[2];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract unit that pushes one nibble per cycle
// through a single 4-bit slice, LSB nibble first.
// Optional zero flag output: define NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN.
// WIDTH must be a multiple of 4 and at least 8.
module nibble_serial_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  adder_state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
  logic             zacc_q, zacc_d;
  logic             zero_q, zero_d;
`endif

  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;

  // Operand nibble select for the current index.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IDX_W'(n)) begin
        slice_a = a_q[n*NIBBLE_W +: NIBBLE_W];
        slice_b = b_q[n*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  nibble_add4 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Next-state, operand capture and result assembly.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
    zacc_d  = zacc_q;
    zero_d  = zero_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1, so invert here and force the carry.
          state_d = RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
          zacc_d  = 1'b1;
          zero_d  = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        for (int n = 0; n < NIBBLES; n++) begin
          if (idx_q == IDX_W'(n)) begin
            sum_d[n*NIBBLE_W +: NIBBLE_W] = slice_sum;
          end
        end
        carry_d = slice_cout;
        idx_d   = idx_q + IDX_W'(1);
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
        // Running all-zero accumulator avoids a full-width compare at the end.
        zacc_d  = zacc_q & ~(|slice_sum);
`endif
        if (idx_q == LAST_IDX) begin
          // slice_sum[3] is the result MSB on the final nibble.
          state_d = DONE;
          idx_d   = '0;
          cout_d  = slice_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (slice_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
          zero_d  = zacc_d;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
      zacc_q  <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
      zacc_q  <= zacc_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
  assign zero     = zero_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16).
module tb_nibble_serial_adder;

  localparam int W = 16;
  localparam int N = W / 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
  logic         zero;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .cin      (cin),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
    ,
    .zero     (zero)
`endif
  );

  function automatic exp_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                 input logic fsub, input logic fcin);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb     = fsub ? ~fb : fb;
    full   = {1'b0, fa} + {1'b0, bb} + {{W{1'b0}}, (fsub ? 1'b1 : fcin)};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (fa[W-1] == bb[W-1]) && (full[W-1] != fa[W-1]);
    e.zero = (full[W-1:0] == '0);
    return e;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic isub, input logic icin);
    a     = ia;
    b     = ib;
    sub   = isub;
    cin   = icin;
    start = 1'b1;
    sb_q.push_back(model(ia, ib, isub, icin));
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    cycle();
    cycle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset.busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset.done got %0b exp 0", done); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL reset.sum got %h exp 0000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset.cout got %0b exp 0", cout); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset.overflow got %0b exp 0", overflow); end
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset.zero got %0b exp 0", zero); end
`endif
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_arith(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tsub, input logic tcin);
    exp_t e;
    e = '0;
    issue(ta, tb_, tsub, tcin);
    for (int c = 1; c <= N + 2; c++) begin
      cycle();
      if (c == 1) begin
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = ~sub; cin = ~cin;
      end
      checks++;
      if (busy !== (c <= N)) begin errors++; $display("FAIL %s.busy cycle %0d got %0b", name, c, busy); end
      checks++;
      if (done !== (c == N + 1)) begin errors++; $display("FAIL %s.done cycle %0d got %0b", name, c, done); end
      if (c == N + 1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL %s.scoreboard empty at done", name);
        end else begin
          e = sb_q.pop_front();
          checks++; if (sum !== e.sum) begin errors++; $display("FAIL %s.sum got %h exp %h", name, sum, e.sum); end
          checks++; if (cout !== e.cout) begin errors++; $display("FAIL %s.cout got %0b exp %0b", name, cout, e.cout); end
          checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL %s.overflow got %0b exp %0b", name, overflow, e.ovf); end
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
          checks++; if (zero !== e.zero) begin errors++; $display("FAIL %s.zero got %0b exp %0b", name, zero, e.zero); end
`endif
        end
      end
      if (c == N + 2) begin
        checks++; if (sum !== e.sum) begin errors++; $display("FAIL %s.sum_hold got %h exp %h", name, sum, e.sum); end
      end
    end
  endtask

  task automatic test_busy();
    exp_t e;
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    for (int c = 1; c <= N + 2; c++) begin
      cycle();
      if (c == 1) start = 1'b0;
      if (c == 2) begin a = 16'hAAAA; b = 16'h5555; start = 1'b1; end
      if (c == 3) start = 1'b0;
      checks++;
      if (busy !== (c <= N)) begin errors++; $display("FAIL busy_prot.busy cycle %0d got %0b", c, busy); end
      checks++;
      if (done !== (c == N + 1)) begin errors++; $display("FAIL busy_prot.done cycle %0d got %0b", c, done); end
      if (c == N + 1) begin
        checks++;
        if (sb_q.size() != 1) begin
          errors++; $display("FAIL busy_prot.scoreboard size %0d exp 1", sb_q.size());
        end else begin
          e = sb_q.pop_front();
          checks++; if (sum !== e.sum) begin errors++; $display("FAIL busy_prot.sum got %h exp %h", sum, e.sum); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    issue(16'h1234, 16'h1111, 1'b0, 1'b0);
    cycle();
    start = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    sb_q.delete();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid.busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid.done got %0b exp 0", done); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL rst_mid.sum got %h exp 0000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL rst_mid.cout got %0b exp 0", cout); end
    cycle();
    issue(16'h0F0F, 16'h0101, 1'b0, 1'b1);
    for (int c = 5; c <= 10; c++) begin
      cycle();
      if (c == 5) start = 1'b0;
      checks++;
      if (busy !== (c >= 5 && c <= 8)) begin errors++; $display("FAIL rst_mid.busy cycle %0d got %0b", c, busy); end
      checks++;
      if (done !== (c == 9)) begin errors++; $display("FAIL rst_mid.done cycle %0d got %0b", c, done); end
      if (c == 9) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL rst_mid.scoreboard empty at done");
        end else begin
          e = sb_q.pop_front();
          checks++; if (sum !== e.sum) begin errors++; $display("FAIL rst_mid.sum2 got %h exp %h", sum, e.sum); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    issue(16'h1234, 16'h4321, 1'b0, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      cycle();
      if (c == 1 || c == 6) start = 1'b0;
      checks++;
      if (busy !== ((c >= 1 && c <= 4) || (c >= 6 && c <= 9))) begin
        errors++; $display("FAIL b2b.busy cycle %0d got %0b", c, busy);
      end
      checks++;
      if (done !== (c == 5 || c == 10)) begin errors++; $display("FAIL b2b.done cycle %0d got %0b", c, done); end
      if (c == 5 || c == 10) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL b2b.scoreboard empty at cycle %0d", c);
        end else begin
          e = sb_q.pop_front();
          checks++; if (sum !== e.sum) begin errors++; $display("FAIL b2b.sum cycle %0d got %h exp %h", c, sum, e.sum); end
          checks++; if (cout !== e.cout) begin errors++; $display("FAIL b2b.cout cycle %0d got %0b exp %0b", c, cout, e.cout); end
        end
      end
      if (c == 5) issue(16'h0001, 16'h0001, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_arith("add", 16'h1234, 16'h4321, 1'b0, 1'b0);
    test_arith("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    test_arith("add_cin", 16'h0FFF, 16'h7000, 1'b0, 1'b1);
    test_arith("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1);
    test_arith("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0);
    test_arith("sub_zero", 16'h3C3C, 16'h3C3C, 1'b1, 1'b0);
    test_arith("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      test_arith("random", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end
    test_busy();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
